// File: rtl/processor_nios_ii_cpu_debug_pkg.sv
// processor_nios_ii_cpu_debug_pkg: FSM/command types and jdo field positions for the OCI memory controller
package processor_nios_ii_cpu_debug_pkg;
    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;
    typedef enum logic [1:0] {LOAD, LOAD_RD, WR, RD_NEXT} cmd_t;
    localparam int JDO_RDFLAG   = 34;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_DATA_LSB = 3;
endpackage

// File: rtl/processor_nios_ii_cpu_debug_wait_timer.sv
// processor_nios_ii_cpu_debug_wait_timer: saturating wait counter, expired once LIMIT waits are counted
module processor_nios_ii_cpu_debug_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(LIMIT);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/processor_nios_ii_cpu_debug_ocimem_ctrl.sv
// processor_nios_ii_cpu_debug_ocimem_ctrl: JTAG/CPU arbiter and sequencer for the OCI RAM; optional wait timeout via NIOS_DBG_OCIMEM_TIMEOUT_EN
module processor_nios_ii_cpu_debug_ocimem_ctrl
    import processor_nios_ii_cpu_debug_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    state_t state;
    cmd_t cmd;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata;
    logic take, multi, wr_bad, expired, jtag_en;
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
    assign take    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi   = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                     (take_action_ocimem_b & take_no_action_ocimem_a);
    assign wr_bad  = state == REQ && cmd == WR && !debugack;
    assign jtag_en = state == REQ && !cpu_req && !wr_bad && !expired;
`ifdef NIOS_DBG_OCIMEM_TIMEOUT_EN
    processor_nios_ii_cpu_debug_wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != REQ),
        .inc     (state == REQ && cpu_req && !wr_bad),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif
    // CPU has fixed priority; JTAG only reaches the port in REQ when the CPU is idle
    assign cpu_gnt   = cpu_req;
    assign mem_en    = cpu_req | jtag_en;
    assign mem_we    = cpu_req ? cpu_we : jtag_en && cmd == WR;
    assign mem_addr  = cpu_req ? cpu_addr : addr;
    assign mem_wdata = cpu_req ? cpu_wdata : wdata;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state         <= IDLE;
            cmd           <= LOAD;
            addr          <= '0;
            wdata         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else if (state == IDLE && take) begin
            monitor_error <= multi;
            if (take_action_ocimem_a) begin
                addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                cmd  <= jdo[JDO_RDFLAG] ? LOAD_RD : LOAD;
                if (jdo[JDO_RDFLAG]) begin
                    state         <= REQ;
                    monitor_ready <= 1'b0;
                end
            end else begin
                cmd           <= take_action_ocimem_b ? WR : RD_NEXT;
                wdata         <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                state         <= REQ;
                monitor_ready <= 1'b0;
            end
        end else begin
            if (take) monitor_error <= 1'b1;
            if (state == REQ) begin
                if (wr_bad || expired) begin
                    monitor_error <= 1'b1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end else if (jtag_en) begin
                    if (cmd != LOAD_RD) addr <= addr + 1'b1;
                    if (cmd == WR) monitor_ready <= 1'b1;
                    state <= cmd == WR ? IDLE : CAPT;
                end
            end else if (state == CAPT) begin
                MonDReg       <= mem_rdata;
                monitor_ready <= 1'b1;
                state         <= IDLE;
            end
        end
endmodule

// File: tb/tb_processor_nios_ii_cpu_debug_ocimem_ctrl.sv
// tb_processor_nios_ii_cpu_debug_ocimem_ctrl: directed vector table plus multi-cycle sequences against a behavioural RAM
module tb_processor_nios_ii_cpu_debug_ocimem_ctrl;
`ifdef NIOS_DBG_OCIMEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 1'b0, reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic ta = 1'b0, tb = 1'b0, tn = 1'b0, debugack = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h33;
    logic [31:0] cpu_wdata = '0;
    logic cpu_gnt, mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, MonDReg;
    logic monitor_ready, monitor_error;
    logic [31:0] ram [256];
    int checks = 0, errors = 0;

    processor_nios_ii_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .take_no_action_ocimem_a(tn),
        .debugack(debugack), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_pulse(input logic a, input logic b, input logic n, input logic rd,
                             input logic [7:0] ad, input logic [31:0] d);
        jdo = '0;
        if (a) begin
            jdo[34] = rd;
            jdo[24:17] = ad;
        end else jdo[34:3] = d;
        ta = a;
        tb = b;
        tn = n;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic a, b, n, rd;
        logic [7:0] addr;
        logic [31:0] data;
        logic dack;
        int lat;
        logic [31:0] mon;
        logic err;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | i;
        ram[8'h10] = 32'hDEAD_BEEF;
        mem_rdata = '0;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 32'h0,         1'b1, 3, 32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 3, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 3, 32'hA500_0011, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h0,         1'b1, 1, 32'hA500_0011, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h1234_5678, 1'b1, 2, 32'hA500_0011, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 3, 32'hA500_0000, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 32'h0,         1'b1, 3, 32'h1234_5678, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'hCAFE_F00D, 1'b0, 2, 32'h1234_5678, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,         1'b1, 3, 32'h1234_5678, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 32'h0,         1'b1, 3, 32'hA500_0020, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0BAD_F00D, 1'b1, 2, 32'hA500_0020, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 32'h0,         1'b1, 3, 32'h0BAD_F00D, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_ready", {31'b0, monitor_ready}, 32'h1);
        chk("rst_error", {31'b0, monitor_error}, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        reset_n = 1'b1;

        // table of single commands with the port free
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            debugack = tbl[i].dack;
            set_pulse(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].rd, tbl[i].addr, tbl[i].data);
            next_cycle();
            set_pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
            lat = 1;
            @(negedge clk);
            while (!monitor_ready && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("row%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("row%0d_mondreg", i), MonDReg, tbl[i].mon);
            chk($sformatf("row%0d_error", i), {31'b0, monitor_error}, {31'b0, tbl[i].err});
            debugack = 1'b1;
        end
        chk("ram_ff_written", ram[8'hFF], 32'h1234_5678);
        chk("ram_20_written", ram[8'h20], 32'h0BAD_F00D);

        // CPU contention: cpu_req held in cycles 1..5
        next_cycle();
        set_pulse(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 32'h0);
        cpu_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            set_pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
            cpu_req = c <= 5;
            @(negedge clk);
            chk($sformatf("cont_c%0d_gnt", c), {31'b0, cpu_gnt}, {31'b0, c <= 5});
            chk($sformatf("cont_c%0d_en", c), {31'b0, mem_en}, {31'b0, c <= 6});
            if (c <= 6) chk($sformatf("cont_c%0d_addr", c), {24'b0, mem_addr}, c <= 5 ? 32'h33 : 32'h40);
            chk($sformatf("cont_c%0d_ready", c), {31'b0, monitor_ready}, {31'b0, c >= 8});
        end
        chk("cont_mondreg", MonDReg, 32'hA500_0040);

        // long CPU hold: aborts at cycle 16 with the timer, otherwise waits it out
        next_cycle();
        set_pulse(1'b1, 1'b0, 1'b0, 1'b1, 8'h50, 32'h0);
        cpu_req = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            next_cycle();
            set_pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
            cpu_req = c <= 20;
            @(negedge clk);
            chk($sformatf("hold_c%0d_en", c), {31'b0, mem_en}, {31'b0, c <= 20 || (!TO_EN && c == 21)});
            if (c <= 20) chk($sformatf("hold_c%0d_addr", c), {24'b0, mem_addr}, 32'h33);
            chk($sformatf("hold_c%0d_ready", c), {31'b0, monitor_ready}, {31'b0, TO_EN ? c >= 17 : c >= 23});
        end
        chk("hold_error", {31'b0, monitor_error}, {31'b0, TO_EN});
        if (!TO_EN) chk("hold_mondreg", MonDReg, 32'hA500_0050);

        // collision: b pulse while a read waits in REQ
        next_cycle();
        set_pulse(1'b1, 1'b0, 1'b0, 1'b1, 8'h60, 32'h0);
        cpu_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 1) set_pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 32'hFFFF_0000);
            else set_pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
            cpu_req = c <= 2;
            @(negedge clk);
            if (c == 2) chk("coll_error_c2", {31'b0, monitor_error}, 32'h1);
            if (c == 3) chk("coll_access_c3", {22'b0, mem_en, mem_we, mem_addr}, {22'b0, 1'b1, 1'b0, 8'h60});
            chk($sformatf("coll_c%0d_ready", c), {31'b0, monitor_ready}, {31'b0, c >= 5});
        end
        chk("coll_mondreg", MonDReg, 32'hA500_0060);
        chk("coll_error", {31'b0, monitor_error}, 32'h1);
        chk("coll_ram_60", ram[8'h60], 32'hA500_0060);

        // reset during CAPT
        next_cycle();
        set_pulse(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 32'h0);
        next_cycle();
        set_pulse(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_error_before", {31'b0, monitor_error}, 32'h1);
        chk("rstmid_ready_before", {31'b0, monitor_ready}, 32'h0);
        reset_n = 1'b0;
        #1;
        chk("rstmid_mondreg", MonDReg, 32'h0);
        chk("rstmid_ready", {31'b0, monitor_ready}, 32'h1);
        chk("rstmid_error", {31'b0, monitor_error}, 32'h0);
        chk("rstmid_mem_en", {31'b0, mem_en}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("postrst_ready", {31'b0, monitor_ready}, 32'h1);
        chk("postrst_mondreg", MonDReg, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
